// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned BeW   = 4;

  localparam logic [BeW-1:0] BeNone = 4'b0000;
  localparam logic [BeW-1:0] BeWord = 4'b1111;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive port-0 grants taken while port 1 was waiting; saturates at the
// limit, at which point port 1 is forced through on the next contested arbitration.
module arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic p0_win,
  input  logic p1_win,
  input  logic p1_wait,
  output logic force_p1
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (p1_win) begin
      cnt_d = '0;
    end else if (p0_win) begin
      if (!p1_wait) begin
        cnt_d = '0;
      end else if (cnt_q != Limit) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_p1 = (cnt_q == Limit);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous data memory between the MEM stage (port 0, priority) and a
// debug/DMA loader (port 1). Each access is latched, issued for one cycle, then answered.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [BeW-1:0]    p0_be,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DataW-1:0]  p0_wdata,
  output logic              p0_done,
  output logic [DataW-1:0]  p0_rdata,
  input  logic              p1_req,
  input  logic [BeW-1:0]    p1_be,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DataW-1:0]  p1_wdata,
  output logic              p1_done,
  output logic [DataW-1:0]  p1_rdata,
  output logic              p0_stall,
  output logic [BeW-1:0]    mem_byte_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DataW-1:0]  mem_wdata,
  input  logic [DataW-1:0]  mem_rdata,
  output logic              busy,
  output logic              owner
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [BeW-1:0]    be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DataW-1:0]  wdata_q, wdata_d;

  logic in_issue, in_resp, arb_en;
  logic cand0, cand1, grant0, grant1, force_p1;

  assign in_issue = (state_q == StIssue);
  assign in_resp  = (state_q == StResp);
  assign arb_en   = (state_q == StIdle) | in_resp;

  // The owner still holds its request while its done pulses; it must not be re-granted.
  assign cand0  = p0_req & ~(in_resp & ~owner_q);
  assign cand1  = p1_req & ~(in_resp & owner_q);
  assign grant1 = arb_en & cand1 & (~cand0 | force_p1);
  assign grant0 = arb_en & cand0 & ~grant1;

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .p0_win   (grant0),
    .p1_win   (grant1),
    .p1_wait  (cand1),
    .force_p1 (force_p1)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      StIdle, StResp: state_d = (grant0 | grant1) ? StIssue : StIdle;
      StIssue:        state_d = StResp;
      default:        state_d = StIdle;
    endcase

    if (grant0) begin
      owner_d = 1'b0;
      be_d    = p0_be;
      addr_d  = p0_addr;
      wdata_d = p0_wdata;
    end else if (grant1) begin
      owner_d = 1'b1;
      be_d    = p1_be;
      addr_d  = p1_addr;
      wdata_d = p1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      be_q    <= BeNone;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Reset must block the write even in the cycle it arrives, not just from the next edge.
  assign mem_byte_wr = in_issue ? (be_q & (rst ? BeNone : BeWord)) : BeNone;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

  assign p0_done  = in_resp & ~owner_q & ~rst;
  assign p1_done  = in_resp & owner_q & ~rst;
  assign p0_rdata = p0_done ? mem_rdata : '0;
  assign p1_rdata = p1_done ? mem_rdata : '0;
  assign p0_stall = p0_req & ~p0_done;
  assign busy     = (state_q != StIdle);
  assign owner    = owner_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and randomized checks of dmem_port_arbiter against a cycle-level rule model
// and a word-array memory reference.
module tb_dmem_port_arbiter;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned CNT_W        = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              p0_req, p1_req;
  logic [3:0]        p0_be, p1_be;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [31:0]       p0_wdata, p1_wdata;
  logic              p0_done, p1_done;
  logic [31:0]       p0_rdata, p1_rdata;
  logic              p0_stall;
  logic [3:0]        mem_byte_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic              busy, owner;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .p0_req      (p0_req),
    .p0_be       (p0_be),
    .p0_addr     (p0_addr),
    .p0_wdata    (p0_wdata),
    .p0_done     (p0_done),
    .p0_rdata    (p0_rdata),
    .p1_req      (p1_req),
    .p1_be       (p1_be),
    .p1_addr     (p1_addr),
    .p1_wdata    (p1_wdata),
    .p1_done     (p1_done),
    .p1_rdata    (p1_rdata),
    .p0_stall    (p0_stall),
    .mem_byte_wr (mem_byte_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .owner       (owner)
  );

  // Synchronous memory: registered read of pre-write contents, byte-lane writes.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[9:2]];
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_wr[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: which port holds the memory (-1 none), whether its issue cycle has
  // passed, what it latched, and how many contested grants port 0 has taken in a row.
  int          m_port   = -1;
  int          m_phase  = 0;
  int          m_owner  = 0;
  int          m_starve = 0;
  logic [3:0]  m_be     = '0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wdata  = '0;
  logic [31:0] ref_mem [256];
  bit          ref_ok  [256];
  int          p1_waits = 0;

  logic        obs_done0, obs_done1, obs_busy;
  logic [3:0]  obs_wr;
  logic [31:0] obs_rd0, obs_rd1;

  task tick();
    logic exp_d0, exp_d1, c0, c1;
    int   win, idx;
    @(negedge clk);
    exp_d0 = !rst && m_port == 0 && m_phase == 1;
    exp_d1 = !rst && m_port == 1 && m_phase == 1;
    idx    = int'(m_addr[9:2]);
    check("done0", 32'(p0_done), 32'(exp_d0));
    check("done1", 32'(p1_done), 32'(exp_d1));
    check("busy", 32'(busy), 32'(m_port >= 0));
    check("owner", 32'(owner), 32'(m_owner));
    check("stall", 32'(p0_stall), 32'(p0_req && !exp_d0));
    check("byte_wr", 32'(mem_byte_wr), (!rst && m_port >= 0 && m_phase == 0) ? 32'(m_be) : 0);
    check("mem_addr", mem_addr, m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    if (!exp_d0) check("rdata0_idle", p0_rdata, 0);
    if (!exp_d1) check("rdata1_idle", p1_rdata, 0);
    if ((exp_d0 || exp_d1) && m_be == 4'b0000 && ref_ok[idx])
      check("rdata", exp_d0 ? p0_rdata : p1_rdata, ref_mem[idx]);
    if ((exp_d0 || exp_d1) && m_be != 4'b0000) begin
      for (int b = 0; b < 4; b++) if (m_be[b]) ref_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
      ref_ok[idx] = ref_ok[idx] || (m_be == 4'b1111);
    end
    if (exp_d0 && p1_req) p1_waits++;
    if (exp_d1) begin
      check("p1_wait_bound", 32'(p1_waits <= int'(STARVE_LIMIT) + 1), 1);
      p1_waits = 0;
    end
    obs_done0 = p0_done; obs_done1 = p1_done; obs_busy = busy; obs_wr = mem_byte_wr;
    obs_rd0 = p0_rdata; obs_rd1 = p1_rdata;

    if (rst) begin
      m_port = -1; m_phase = 0; m_owner = 0; m_starve = 0;
      m_be = '0; m_addr = '0; m_wdata = '0; p1_waits = 0;
    end else if (m_port >= 0 && m_phase == 0) begin
      m_phase = 1;
    end else begin
      c0  = p0_req && m_port != 0;
      c1  = p1_req && m_port != 1;
      win = -1;
      if (c0 && c1)  win = (m_starve == int'(STARVE_LIMIT)) ? 1 : 0;
      else if (c0)   win = 0;
      else if (c1)   win = 1;
      if (win == 0) m_starve = !c1 ? 0 : (m_starve < int'(STARVE_LIMIT) ? m_starve + 1 : m_starve);
      if (win == 1) m_starve = 0;
      m_port = win;
      if (win >= 0) begin
        m_phase = 0;
        m_owner = win;
        m_be    = (win == 1) ? p1_be : p0_be;
        m_addr  = (win == 1) ? p1_addr : p0_addr;
        m_wdata = (win == 1) ? p1_wdata : p0_wdata;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int port, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output int lat);
    bit got = 0;
    if (port == 0) begin p0_be = be; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1; end
    else           begin p1_be = be; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1; end
    lat = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      lat++;
      if ((port == 0) ? obs_done0 : obs_done1) got = 1;
    end
    check("access_done_seen", 32'(got), 1);
    if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
    rd = (port == 0) ? obs_rd0 : obs_rd1;
  endtask

  task automatic new_txn(output logic [3:0] be, output logic [31:0] addr,
                         output logic [31:0] wdata);
    case ($urandom_range(0, 3))
      0, 3:    be = 4'b0000;
      1:       be = 4'b1111;
      default: be = 4'($urandom);
    endcase
    addr  = 32'h100 + 32'($urandom_range(0, 15)) * 4;
    wdata = $urandom;
  endtask

  initial begin
    logic [31:0] rd;
    int          lat, gap, pct;
    bit          seen;

    rst = 1'b1;
    p0_req = 0; p0_be = '0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_be = '0; p1_addr = '0; p1_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    tick();
    check("rst_busy", 32'(obs_busy), 0);
    check("rst_byte_wr", 32'(obs_wr), 0);
    rst = 1'b0;
    tick();

    // Single p0 write then read back.
    access(0, 4'b1111, 32'h100, 32'hCE9C9698, rd, lat);
    check("wr_latency", 32'(lat), 3);
    access(0, 4'b0000, 32'h100, 32'h0, rd, lat);
    check("rd_latency", 32'(lat), 3);
    check("rd_back", rd, 32'hCE9C9698);

    // Upper-half byte write merges into an existing word.
    access(0, 4'b1111, 32'h104, 32'h11223344, rd, lat);
    access(1, 4'b1100, 32'h104, 32'hAABB0000, rd, lat);
    access(0, 4'b0000, 32'h104, 32'h0, rd, lat);
    check("partial_merge", rd, 32'hAABB3344);

    // p0 arrives while p1 is answering: straight to ISSUE, p0 done two cycles later.
    p1_be = 4'b1111; p1_addr = 32'h108; p1_wdata = 32'h55667788; p1_req = 1'b1;
    tick();
    tick();
    p0_be = 4'b0000; p0_addr = 32'h108; p0_wdata = '0; p0_req = 1'b1;
    tick();
    check("x_p1_done", 32'(obs_done1), 1);
    p1_req = 1'b0;
    gap  = 0;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      gap++;
      if (gap == 1) check("x_no_idle", 32'(obs_busy), 1);
      if (obs_done0) seen = 1;
    end
    p0_req = 1'b0;
    check("x_done_gap", 32'(gap), 2);
    check("x_rdata", obs_rd0, 32'h55667788);

    // Reset during the issue cycle of a write: nothing commits, no done.
    access(0, 4'b1111, 32'h10C, 32'h01234567, rd, lat);
    p0_be = 4'b1111; p0_addr = 32'h10C; p0_wdata = 32'hDEADBEEF; p0_req = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("rst_issue_wr", 32'(obs_wr), 0);
    check("rst_issue_done", 32'(obs_done0), 0);
    rst = 1'b0;
    p0_req = 1'b0;
    tick();
    check("rst_idle", 32'(obs_busy), 0);
    check("rst_no_done", 32'(obs_done0), 0);
    access(0, 4'b0000, 32'h10C, 32'h0, rd, lat);
    check("rst_mem_kept", rd, 32'h01234567);

    // Request dropped after latching still completes; later input changes are ignored.
    p0_be = 4'b1111; p0_addr = 32'h110; p0_wdata = 32'h0BADF00D; p0_req = 1'b1;
    tick();
    p0_req = 1'b0; p0_addr = 32'h114; p0_wdata = 32'hFFFFFFFF;
    tick();
    tick();
    check("drop_done", 32'(obs_done0), 1);
    access(0, 4'b0000, 32'h110, 32'h0, rd, lat);
    check("drop_data", rd, 32'h0BADF00D);

    // Random traffic: moderate load, then both ports saturated, then drain.
    for (int cyc = 0; cyc < 700; cyc++) begin
      pct = (cyc < 300) ? 55 : (cyc < 680) ? 100 : 0;
      tick();
      if (obs_done0) p0_req = 1'b0;
      if (obs_done1) p1_req = 1'b0;
      if (!p0_req && $urandom_range(0, 99) < pct) begin
        new_txn(p0_be, p0_addr, p0_wdata);
        p0_req = 1'b1;
      end
      if (!p1_req && $urandom_range(0, 99) < pct) begin
        new_txn(p1_be, p1_addr, p1_wdata);
        p1_req = 1'b1;
      end
    end
    tick();
    check("final_idle", 32'(obs_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
